// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_t  : operand-forwarding select carried into E
//   sb_entry_t : one in-flight destination record (E, M or W)
// rd is held at a fixed 8-bit width so one struct serves any REG_BITS up to 8.
package pipe_ctrl_pkg;

   localparam int SB_RD_W    = 8;
   localparam int PC_REG_DEF = 15;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic               valid;
      logic [SB_RD_W-1:0] rd;
      logic               is_load;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   // A decode source depends on an in-flight entry; the PC register never does.
   function automatic logic src_match(input sb_entry_t          ent,
                                      input logic               use_src,
                                      input logic [SB_RD_W-1:0] src,
                                      input logic [SB_RD_W-1:0] pc_reg);
      return use_src & ent.valid & (ent.rd == src) & (src != pc_reg);
   endfunction

   // Youngest producer first. A load in E never reaches here because it stalls.
   function automatic fwd_sel_t fwd_pick(input logic hit_e,
                                         input logic e_is_load,
                                         input logic hit_m);
      if (hit_e && !e_is_load) return FWD_M;
      else if (hit_m)          return FWD_W;
      else                     return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: E -> M -> W shift register of in-flight destinations.
// A bubble request loads an empty entry into E in place of the decode entry.
module hazard_scoreboard
   import pipe_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  sb_entry_t dec_entry,
   input  logic      bubble,
   output sb_entry_t sb_e,
   output sb_entry_t sb_m,
   output sb_entry_t sb_w
);

   sb_entry_t sb_e_q, sb_e_d;
   sb_entry_t sb_m_q, sb_m_d;
   sb_entry_t sb_w_q, sb_w_d;

   // Next contents: every entry advances one stage each cycle.
   always_comb begin
      sb_e_d = bubble ? SB_EMPTY : dec_entry;
      sb_m_d = sb_e_q;
      sb_w_d = sb_m_q;
   end

   // Scoreboard storage, emptied by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_e_q <= SB_EMPTY;
         sb_m_q <= SB_EMPTY;
         sb_w_q <= SB_EMPTY;
      end else begin
         sb_e_q <= sb_e_d;
         sb_m_q <= sb_m_d;
         sb_w_q <= sb_w_d;
      end
   end

   assign sb_e = sb_e_q;
   assign sb_m = sb_m_q;
   assign sb_w = sb_w_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / flush / forwarding control for the F D E M W pipe.
// Optional macro PIPE_HAZARD_CTRL_PERF_EN adds saturating StallCnt/FlushCnt.
//
// redirect counter | meaning
// -----------------+------------------------------------------------
// 0                | idle, FlushD only follows BranchTakenE
// 1..BR_EXTRA      | extra redirect cycles left, FlushD held high
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_BITS = 4,
   parameter int PC_REG   = PC_REG_DEF,
   parameter int BR_EXTRA = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ValidD,
   input  logic [REG_BITS-1:0] RnD,
   input  logic [REG_BITS-1:0] RmD,
   input  logic                UseRnD,
   input  logic                UseRmD,
   input  logic [REG_BITS-1:0] RdD,
   input  logic                RegWriteD,
   input  logic                MemToRegD,
   input  logic                BranchTakenE,
   output logic                StallF,
   output logic                StallD,
   output logic                FlushD,
   output logic                FlushE,
   output logic [1:0]          FwdAE,
   output logic [1:0]          FwdBE
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [15:0]         StallCnt,
   output logic [15:0]         FlushCnt
`endif
);

   localparam int BR_W = 3;

   logic [SB_RD_W-1:0] rn_x, rm_x, rd_x, pc_x;
   sb_entry_t          dec_entry, sb_e, sb_m, sb_w_unused;
   logic               hit_a_e, hit_b_e, hit_a_m, hit_b_m;
   logic               load_use, br_busy;
   logic               stall, flush_d, flush_e;
   logic [BR_W-1:0]    br_cnt_q, br_cnt_d;
   fwd_sel_t           fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

   assign rn_x = SB_RD_W'(RnD);
   assign rm_x = SB_RD_W'(RmD);
   assign rd_x = SB_RD_W'(RdD);
   assign pc_x = SB_RD_W'(PC_REG);

   // Decode entry: only real, register-writing instructions become producers.
   always_comb begin
      dec_entry         = SB_EMPTY;
      dec_entry.valid   = ValidD & RegWriteD;
      dec_entry.rd      = rd_x;
      dec_entry.is_load = MemToRegD;
   end

   hazard_scoreboard u_sb (
      .clk       (clk),
      .reset     (reset),
      .dec_entry (dec_entry),
      .bubble    (flush_e),
      .sb_e      (sb_e),
      .sb_m      (sb_m),
      .sb_w      (sb_w_unused)
   );

   // Source-to-producer matches; an empty decode slot matches nothing.
   always_comb begin
      hit_a_e = ValidD & src_match(sb_e, UseRnD, rn_x, pc_x);
      hit_b_e = ValidD & src_match(sb_e, UseRmD, rm_x, pc_x);
      hit_a_m = ValidD & src_match(sb_m, UseRnD, rn_x, pc_x);
      hit_b_m = ValidD & src_match(sb_m, UseRmD, rm_x, pc_x);
   end

   // Stall/flush decisions; a pending redirect wins over a load-use stall.
   always_comb begin
      load_use = sb_e.is_load & (hit_a_e | hit_b_e);
      br_busy  = BranchTakenE | (br_cnt_q != '0);
      stall    = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      if (!reset) begin
         stall   = load_use & ~br_busy;
         flush_d = br_busy;
         flush_e = load_use | BranchTakenE;
      end
   end

   assign StallF = stall;
   assign StallD = stall;
   assign FlushD = flush_d;
   assign FlushE = flush_e;

   // Forward selects for the instruction entering E; a bubble gets RF.
   always_comb begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (!flush_e) begin
         fwd_a_d = fwd_pick(hit_a_e, sb_e.is_load, hit_a_m);
         fwd_b_d = fwd_pick(hit_b_e, sb_e.is_load, hit_b_m);
      end
   end

   // Redirect down-counter: a taken branch (re)loads the extra penalty.
   always_comb begin
      br_cnt_d = br_cnt_q;
      if (BranchTakenE)         br_cnt_d = BR_W'(BR_EXTRA);
      else if (br_cnt_q != '0)  br_cnt_d = br_cnt_q - 1'b1;
   end

   // Registered forward selects and redirect counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_a_q  <= FWD_RF;
         fwd_b_q  <= FWD_RF;
         br_cnt_q <= '0;
      end else begin
         fwd_a_q  <= fwd_a_d;
         fwd_b_q  <= fwd_b_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   assign FwdAE = fwd_a_q;
   assign FwdBE = fwd_b_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counts: load-use stall cycles and taken branches.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (BranchTakenE && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   // Event counter storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`endif

endmodule
